runner_control: RTL and testbench

- Upstream control FSM for the runner-game pixel datapath. It sequences the floor, erase, tree, man and game-over draw passes, handshaking on the datapath's *_finish flags.
- Owns game state: lane, crouch, obstacle column x, obstacle shapes (LFSR), per-frame timing, collision and score.
- Loads the datapath registers through one-cycle ld_* strobes once per frame.

---
 rtl/runner_control_pkg.sv | 49 ++++
 rtl/runner_lfsr8.sv | 26 ++
 rtl/runner_control.sv | 209 ++++++++++++++++++++
 tb/tb_runner_control.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/runner_control_pkg.sv
// Shared definitions for the runner-game control path and its pixel datapath:
// FSM encoding, obstacle shape codes, screen geometry, colours and the shape LFSR step.
package runner_control_pkg;

    typedef enum logic [3:0] {
        ST_FLOORS   = 4'd0,
        ST_IDLE     = 4'd1,
        ST_ERASE    = 4'd2,
        ST_TREE     = 4'd3,
        ST_MAN      = 4'd4,
        ST_WAIT     = 4'd5,
        ST_UPDATE   = 4'd6,
        ST_CHECK    = 4'd7,
        ST_GAMEOVER = 4'd8,
        ST_DONE     = 4'd9
    } state_t;

    localparam logic [1:0] SHAPE_OPEN = 2'b00;
    localparam logic [1:0] SHAPE_LOW  = 2'b10;
    localparam logic [1:0] SHAPE_WALL = 2'b11;

    localparam logic [6:0] MAN_Y_TOP   = 7'd28;
    localparam logic [6:0] MAN_Y_MID   = 7'd68;
    localparam logic [6:0] MAN_Y_BOT   = 7'd108;
    localparam logic [6:0] FLOOR_Y_TOP = 7'd38;
    localparam logic [6:0] FLOOR_Y_MID = 7'd78;
    localparam logic [6:0] FLOOR_Y_BOT = 7'd118;

    localparam logic [2:0] COLOUR_BG    = 3'b000;
    localparam logic [2:0] COLOUR_FLOOR = 3'b111;
    localparam logic [2:0] COLOUR_TREE  = 3'b010;
    localparam logic [2:0] COLOUR_MAN   = 3'b110;
    localparam logic [2:0] COLOUR_OVER  = 3'b100;

    // Fibonacci step, taps 8,6,5,4, feedback shifted into bit 0.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // {bottom, mid, top}; three walls would be unpassable, so bottom becomes a low bar.
    function automatic logic [5:0] spawn_shapes(input logic [7:0] s);
        if (s[5:0] == 6'b11_11_11) begin
            return {SHAPE_LOW, SHAPE_WALL, SHAPE_WALL};
        end else begin
            return s[5:0];
        end
    endfunction

endpackage

// File: rtl/runner_lfsr8.sv
// 8-bit shape LFSR with a nonzero seed and a single-step enable.
module runner_lfsr8
    import runner_control_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       step,
    output logic [7:0] state
);

    logic [7:0] state_r;

    // LFSR register, advances only when stepped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= SEED;
        end else if (step) begin
            state_r <= lfsr8_next(state_r);
        end
    end

    assign state = state_r;

endmodule

// File: rtl/runner_control.sv
// Runner-game control FSM: sequences datapath draw passes, runs the frame timer
// and owns lane, obstacle position/shapes, collision and score.
module runner_control
    import runner_control_pkg::*;
#(
    parameter int unsigned FRAME_TICKS  = 833333,
    parameter int unsigned TREE_X_START = 156,
    parameter int unsigned TREE_STEP    = 2,
    parameter int unsigned MAN_X        = 25,
    parameter logic [6:0]  LANE_Y0      = MAN_Y_TOP,
    parameter logic [6:0]  LANE_Y1      = MAN_Y_MID,
    parameter logic [6:0]  LANE_Y2      = MAN_Y_BOT,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       lane_up,
    input  logic       lane_down,
    input  logic       crouch,
    input  logic       draw_floors_finish,
    input  logic       erase_finish,
    input  logic       draw_tree_finish,
    input  logic       draw_man_finish,
    input  logic       draw_gameover_finish,
    output logic       drawing_floors,
    output logic       erase,
    output logic       draw_tree,
    output logic       draw_man,
    output logic       gameover,
    output logic       ld_x,
    output logic       ld_y,
    output logic       ld_man_style,
    output logic       ld_shape,
    output logic       update,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic       man_style,
    output logic [1:0] top,
    output logic [1:0] mid,
    output logic [1:0] bottom,
    output logic [7:0] score
);

    localparam logic [19:0] TICK_LAST     = 20'(FRAME_TICKS - 1);
    localparam logic [7:0]  X_START       = 8'(TREE_X_START);
    localparam logic [7:0]  X_STEP        = 8'(TREE_STEP);
    localparam logic [7:0]  RESPAWN_BELOW = 8'(TREE_STEP + 1);
    localparam logic [8:0]  OVL_LO        = 9'(MAN_X);
    localparam logic [8:0]  OVL_HI        = 9'(MAN_X + 6);

    state_t      state_r;
    state_t      next_s;
    logic [19:0] timer_r;
    logic [1:0]  lane_r;
    logic        up_hist_r;
    logic        down_hist_r;
    logic        up_edge_s;
    logic        down_edge_s;
    logic        enter_update_s;
    logic        respawn_s;
    logic [7:0]  lfsr_s;
    logic [5:0]  new_shapes_s;
    logic [6:0]  lane_y_s;
    logic [1:0]  lane_shape_s;
    logic        overlap_s;
    logic        collide_s;

    assign up_edge_s      = lane_up & ~up_hist_r;
    assign down_edge_s    = lane_down & ~down_hist_r;
    assign enter_update_s = (next_s == ST_UPDATE);
    assign respawn_s      = (x_out < RESPAWN_BELOW);
    assign new_shapes_s   = spawn_shapes(lfsr8_next(lfsr_s));

    runner_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .step    (enter_update_s & respawn_s),
        .state   (lfsr_s)
    );

    // Next-state logic; every pass is held until its finish flag is seen.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_FLOORS:   if (draw_floors_finish)   next_s = ST_IDLE;     else next_s = ST_FLOORS;
            ST_IDLE:     if (start)                next_s = ST_ERASE;    else next_s = ST_IDLE;
            ST_ERASE:    if (erase_finish)         next_s = ST_TREE;     else next_s = ST_ERASE;
            ST_TREE:     if (draw_tree_finish)     next_s = ST_MAN;      else next_s = ST_TREE;
            ST_MAN:      if (draw_man_finish)      next_s = ST_WAIT;     else next_s = ST_MAN;
            ST_WAIT:     if (timer_r >= TICK_LAST) next_s = ST_UPDATE;   else next_s = ST_WAIT;
            ST_UPDATE:   next_s = ST_CHECK;
            ST_CHECK:    if (collide_s)            next_s = ST_GAMEOVER; else next_s = ST_ERASE;
            ST_GAMEOVER: if (draw_gameover_finish) next_s = ST_DONE;     else next_s = ST_GAMEOVER;
            ST_DONE:     next_s = ST_DONE;
            default:     next_s = ST_FLOORS;
        endcase
    end

    // Lane y lookup and current-lane shape for collision.
    always_comb begin
        lane_y_s     = LANE_Y2;
        lane_shape_s = bottom;
        case (lane_r)
            2'd0:    begin lane_y_s = LANE_Y0; lane_shape_s = top; end
            2'd1:    begin lane_y_s = LANE_Y1; lane_shape_s = mid; end
            default: begin lane_y_s = LANE_Y2; lane_shape_s = bottom; end
        endcase
    end

    // Collision uses 9-bit compares so x_out+1 cannot wrap.
    always_comb begin
        overlap_s = ({1'b0, x_out} <= OVL_HI) && (({1'b0, x_out} + 9'd1) >= OVL_LO);
        if (overlap_s) begin
            collide_s = (lane_shape_s == SHAPE_WALL) || ((lane_shape_s == SHAPE_LOW) && man_style);
        end else begin
            collide_s = 1'b0;
        end
    end

    // State register and frame timer (restarts on each ERASE entry).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_FLOORS;
            timer_r <= 20'd0;
        end else begin
            state_r <= next_s;
            if ((next_s == ST_ERASE) && (state_r != ST_ERASE)) begin
                timer_r <= 20'd0;
            end else begin
                timer_r <= timer_r + 20'd1;
            end
        end
    end

    // Lane register with rising-edge detect; opposing edges cancel, frozen once DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_r      <= 2'd2;
            up_hist_r   <= 1'b0;
            down_hist_r <= 1'b0;
        end else begin
            up_hist_r   <= lane_up;
            down_hist_r <= lane_down;
            if (state_r != ST_DONE) begin
                if (up_edge_s && !down_edge_s && (lane_r != 2'd0)) begin
                    lane_r <= lane_r - 2'd1;
                end else if (down_edge_s && !up_edge_s && (lane_r < 2'd2)) begin
                    lane_r <= lane_r + 2'd1;
                end
            end
        end
    end

    // Enables and strobes decoded from the next state so they align with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drawing_floors <= 1'b1;
            erase          <= 1'b0;
            draw_tree      <= 1'b0;
            draw_man       <= 1'b0;
            gameover       <= 1'b0;
            ld_x           <= 1'b0;
            ld_y           <= 1'b0;
            ld_man_style   <= 1'b0;
            ld_shape       <= 1'b0;
            update         <= 1'b0;
        end else begin
            drawing_floors <= (next_s == ST_FLOORS);
            erase          <= (next_s == ST_ERASE);
            draw_tree      <= (next_s == ST_TREE);
            draw_man       <= (next_s == ST_MAN);
            gameover       <= (next_s == ST_GAMEOVER);
            ld_x           <= enter_update_s;
            ld_y           <= enter_update_s;
            ld_man_style   <= enter_update_s;
            ld_shape       <= enter_update_s;
            update         <= enter_update_s;
        end
    end

    // Game state, loaded on the edge into UPDATE so values are valid with the strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_out     <= X_START;
            y_out     <= LANE_Y2;
            man_style <= 1'b1;
            top       <= SHAPE_OPEN;
            mid       <= SHAPE_LOW;
            bottom    <= SHAPE_WALL;
            score     <= 8'd0;
        end else if (enter_update_s) begin
            y_out     <= lane_y_s;
            man_style <= ~crouch;
            if (respawn_s) begin
                x_out  <= X_START;
                top    <= new_shapes_s[1:0];
                mid    <= new_shapes_s[3:2];
                bottom <= new_shapes_s[5:4];
                if (score != 8'd255) begin
                    score <= score + 8'd1;
                end
            end else begin
                x_out <= x_out - X_STEP;
            end
        end
    end

endmodule

// File: tb/tb_runner_control.sv
// Directed bench for runner_control: a game model pushes expected UPDATE values to a
// scoreboard queue, a small responder plays the datapath finish flags.
module tb_runner_control;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, lane_up, lane_down, crouch;
    logic       draw_floors_finish, erase_finish, draw_tree_finish, draw_man_finish, draw_gameover_finish;
    logic       drawing_floors, erase, draw_tree, draw_man, gameover;
    logic       ld_x, ld_y, ld_man_style, ld_shape, update;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic       man_style;
    logic [1:0] top, mid, bottom;
    logic [7:0] score;

    int total = 0;
    int bad   = 0;
    int d_floor = 5;
    int d_pass  = 2;
    int d_go    = 4;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic       style;
        logic [5:0] shapes;
        logic [7:0] score;
        logic       col;
    } exp_t;
    exp_t sb[$];

    int         x_m, lane_m, score_m;
    logic [7:0] lfsr_m;
    logic [1:0] t_m, m_m, b_m;
    logic [6:0] y_m;

    runner_control #(.FRAME_TICKS(50)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .lane_up(lane_up), .lane_down(lane_down),
        .crouch(crouch), .draw_floors_finish(draw_floors_finish), .erase_finish(erase_finish),
        .draw_tree_finish(draw_tree_finish), .draw_man_finish(draw_man_finish),
        .draw_gameover_finish(draw_gameover_finish), .drawing_floors(drawing_floors),
        .erase(erase), .draw_tree(draw_tree), .draw_man(draw_man), .gameover(gameover),
        .ld_x(ld_x), .ld_y(ld_y), .ld_man_style(ld_man_style), .ld_shape(ld_shape),
        .update(update), .x_out(x_out), .y_out(y_out), .man_style(man_style),
        .top(top), .mid(mid), .bottom(bottom), .score(score)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: each finish rises after its enable has been seen N cycles.
    initial begin
        int cf, ce, ct, cm, cg;
        cf = 0; ce = 0; ct = 0; cm = 0; cg = 0;
        draw_floors_finish = 1'b0; erase_finish = 1'b0; draw_tree_finish = 1'b0;
        draw_man_finish = 1'b0; draw_gameover_finish = 1'b0;
        forever begin
            @(negedge clk);
            cf = (reset_n && drawing_floors) ? cf + 1 : 0;
            ce = (reset_n && erase)          ? ce + 1 : 0;
            ct = (reset_n && draw_tree)      ? ct + 1 : 0;
            cm = (reset_n && draw_man)       ? cm + 1 : 0;
            cg = (reset_n && gameover)       ? cg + 1 : 0;
            draw_floors_finish   = (cf >= d_floor);
            erase_finish         = (ce >= d_pass);
            draw_tree_finish     = (ct >= d_pass);
            draw_man_finish      = (cm >= d_pass);
            draw_gameover_finish = (cg >= d_go);
        end
    end

    function automatic logic [9:0] ctl_bits();
        return {drawing_floors, erase, draw_tree, draw_man, gameover,
                ld_x, ld_y, ld_man_style, ld_shape, update};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bound_hit(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=timeout expected=event", tag);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "run aborted");
    endtask

    task automatic model_reset();
        x_m = 156; lane_m = 2; score_m = 0; lfsr_m = 8'hA5;
        t_m = 2'b00; m_m = 2'b10; b_m = 2'b11; y_m = 7'd108;
        sb.delete();
    endtask

    task automatic check_reset_values();
        chk("rst_ctl", ctl_bits(), 10'b10_0000_0000);
        chk("rst_x", x_out, 156);
        chk("rst_y", y_out, 108);
        chk("rst_style", man_style, 1);
        chk("rst_shapes", {top, mid, bottom}, 6'b00_10_11);
        chk("rst_score", score, 0);
    endtask

    // Apply one frame's stimulus to the model and queue the UPDATE-cycle expectation.
    task automatic model_step(input logic up, input logic dn, input logic cr);
        exp_t e;
        logic [1:0] sh;
        logic st;
        if (up && !dn && lane_m > 0) lane_m--;
        else if (dn && !up && lane_m < 2) lane_m++;
        y_m = (lane_m == 0) ? 7'd28 : (lane_m == 1) ? 7'd68 : 7'd108;
        st = !cr;
        if (x_m < 3) begin
            lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
            t_m = lfsr_m[1:0]; m_m = lfsr_m[3:2]; b_m = lfsr_m[5:4];
            if (t_m == 2'b11 && m_m == 2'b11 && b_m == 2'b11) b_m = 2'b10;
            x_m = 156;
            if (score_m < 255) score_m++;
        end else begin
            x_m = x_m - 2;
        end
        sh = (lane_m == 0) ? t_m : (lane_m == 1) ? m_m : b_m;
        e.x = 8'(x_m); e.y = y_m; e.style = st;
        e.shapes = {t_m, m_m, b_m}; e.score = 8'(score_m);
        e.col = (x_m <= 31) && (x_m + 1 >= 25) && (sh == 2'b11 || (sh == 2'b10 && st));
        sb.push_back(e);
    endtask

    // One game frame from the first ERASE cycle through the CHECK decision.
    task automatic do_frame(input logic cr, input logic up, input logic dn,
                            input logic overrun, output logic col);
        int t, g, t_wait;
        logic man_seen;
        logic [6:0] y_before;
        exp_t o;
        g = 0;
        while (!erase && g < 200) begin @(negedge clk); g++; end
        if (g >= 200) bound_hit("erase_wait");
        if (overrun) d_pass = 20;
        y_before = y_m;
        crouch = cr; lane_up = up; lane_down = dn;
        model_step(up, dn, cr);
        t = 0; t_wait = -1; man_seen = 1'b0;
        @(negedge clk); t = 1;
        lane_up = 1'b0; lane_down = 1'b0;
        chk("y_held_until_update", y_out, y_before);
        while (!ld_x && t < 400) begin
            if (draw_man) man_seen = 1'b1;
            else if (man_seen && t_wait < 0) t_wait = t;
            @(negedge clk); t++;
        end
        if (t >= 400) bound_hit("ld_wait");
        if (overrun) begin
            chk("overrun_wait_len", t - t_wait, 1);
            chk("overrun_late", t > 50, 1);
            d_pass = 2;
        end else begin
            chk("frame_ticks", t, 50);
        end
        o = sb.pop_front();
        chk("upd_strobes", {ld_y, ld_man_style, ld_shape, update}, 4'hF);
        chk("upd_x", x_out, o.x);
        chk("upd_y", y_out, o.y);
        chk("upd_style", man_style, o.style);
        chk("upd_shapes", {top, mid, bottom}, o.shapes);
        chk("upd_score", score, o.score);
        @(negedge clk);
        chk("strobe_one_cycle", {ld_x, ld_y, ld_man_style, ld_shape, update}, 5'd0);
        @(negedge clk);
        chk("check_exit", {gameover, erase}, o.col ? 2'b10 : 2'b01);
        col = o.col;
    endtask

    initial begin
        logic col, over;
        int g;
        reset_n = 1'b0; start = 1'b0; lane_up = 1'b0; lane_down = 1'b0; crouch = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values();
        #2 reset_n = 1'b1;

        // Floors pass, then IDLE waits for start.
        g = 0;
        @(negedge clk);
        while (drawing_floors && g < 50) begin g++; @(negedge clk); end
        chk("floors_len", g, 5);
        repeat (2) @(negedge clk);
        chk("idle_quiet", ctl_bits(), 10'd0);
        start = 1'b1;

        // Run 1: mid lane crouching past the low bar, then up to top; third up and up+down hold.
        for (int f = 1; f <= 78; f++)
            do_frame(1'b1, (f == 2 || f == 70 || f == 72 || f == 74), (f == 74), (f == 10), col);
        // Runs 2..5: drop to bottom lane early, keep crouching.
        for (int r = 2; r <= 5; r++)
            for (int f = 1; f <= 78; f++)
                do_frame(1'b1, 1'b0, (r == 2 && (f == 3 || f == 5)), 1'b0, col);
        // Run 6: standing in the bottom lane against a low bar ends the game.
        over = 1'b0;
        for (int f = 1; f <= 78 && !over; f++)
            do_frame(1'b0, 1'b0, 1'b0, 1'b0, over);

        g = 0;
        while (!draw_gameover_finish && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) bound_hit("gameover_finish_wait");
        chk("gameover_held", gameover, 1);
        @(negedge clk);
        chk("done_idle", ctl_bits(), 10'd0);
        start = 1'b1; lane_up = 1'b1;
        repeat (6) @(negedge clk);
        chk("done_ignores_start", ctl_bits(), 10'd0);
        lane_up = 1'b0;

        // Fresh game after reset, then reset in the middle of the tree pass.
        reset_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        #2 reset_n = 1'b1;
        model_reset();
        do_frame(1'b0, 1'b0, 1'b0, 1'b0, col);
        do_frame(1'b0, 1'b0, 1'b0, 1'b0, col);
        g = 0;
        while (!draw_tree && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) bound_hit("tree_wait");
        chk("pre_reset_x", x_out, 152);
        #2 reset_n = 1'b0;
        #1;
        chk("midpass_ctl", ctl_bits(), 10'b10_0000_0000);
        chk("midpass_x", x_out, 156);
        chk("midpass_score", score, 0);
        chk("midpass_y", y_out, 108);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
